// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: IF-stage requester with an in-order fetch queue and FWFT output.
// Latency: a word fetched in cycle N is presented on out_* in cycle N+1; a redirect costs a 1-cycle bubble.
// Backpressure: out_ready=0 fills the queue, then fetch stalls; a full queue that pops still fetches.
// Optional build macro IFU_PERF_CNT_EN adds fetch_cnt/stall_cnt performance counters.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  output logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  logic [31:0]   r_pc;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [31:0]   r_q_instr [QDEPTH];
  logic [31:0]   r_q_pc    [QDEPTH];

  logic          w_pop;
  logic          w_push;
  logic          w_not_full;
  logic [31:0]   w_redirect_pc;
  logic          w_unused_pc_lsb;

  // Low two bits of the redirect target are dropped: instructions are word aligned.
  assign w_redirect_pc   = {redirect_pc[31:2], 2'b00};
  assign w_unused_pc_lsb = ^redirect_pc[1:0];

  assign w_not_full = (r_count < FULL);
  assign out_valid  = !rst && (r_count != '0);
  assign w_pop      = out_valid && out_ready;
  // A pop frees a slot in the same cycle, so a full queue can still accept the fetched word.
  assign w_push     = !rst && !redirect_valid && (w_not_full || w_pop);
  assign fetch_en   = w_push;
  assign imem_addr  = r_pc;

  assign out_instr  = out_valid ? r_q_instr[r_rd_ptr] : 32'h0;
  assign out_pc     = out_valid ? r_q_pc[r_rd_ptr]    : 32'h0;

  // PC, pointers and occupancy; reset beats redirect, redirect beats normal fetch/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (redirect_valid) begin
      r_pc     <= w_redirect_pc;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_pc     <= r_pc + 32'd4;
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Queue storage: capture the fetched word together with the PC it was read from.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_instr[r_wr_ptr] <= imem_rd;
      r_q_pc[r_wr_ptr]    <= r_pc;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;
  logic        w_stall;

  // A stall is a live, non-redirect cycle where the full queue blocked the fetch.
  assign w_stall   = !rst && !redirect_valid && !w_push;
  assign fetch_cnt = r_fetch_cnt;
  assign stall_cnt = r_stall_cnt;

  // Performance counters: cleared only by reset, wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= 32'h0;
      r_stall_cnt <= 32'h0;
    end else begin
      if (w_push) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (w_stall) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
